// File: rtl/prom_writer.sv
// Programming and verify controller for a registered-read PROM: streams words in,
// reads them all back against a shadow copy, and locks the image after a clean verify.
module prom_writer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  locked
);

    // Handshake: a word transfers on any rising clock edge where in_valid && in_ready;
    // in_ready is high for the whole WRITE state and in_data must hold while in_valid waits.

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        VERIFY,
        CHECK_LAST
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   count, count_nxt;
    logic [DATA_WIDTH-1:0]   shadow [DEPTH];

    logic                    start_accept;
    logic                    handshake;
    logic                    cmp_en;
    logic [ADDR_WIDTH-1:0]   cmp_addr;
    logic                    mismatch;
    logic                    run_ok;

    assign start_accept = (state == IDLE) && start && !locked;
    assign handshake    = (state == WRITE) && in_valid;

    // Read data lags the issued address by one cycle, so the first VERIFY cycle has nothing to compare.
    assign cmp_en   = ((state == VERIFY) && (count != '0)) || (state == CHECK_LAST);
    assign cmp_addr = (state == CHECK_LAST) ? LAST_ADDR : count - 1'b1;
    assign mismatch = cmp_en && (mem_rd_data != shadow[cmp_addr]);
    assign run_ok   = (state == CHECK_LAST) && !error && !mismatch;

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        in_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_rd_en   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (start_accept) begin
                    state_nxt = WRITE;
                    count_nxt = '0;
                end
            end
            WRITE: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                mem_addr = count;
                if (in_valid) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = in_data;
                    count_nxt   = count + 1'b1;
                    if (count == LAST_ADDR) state_nxt = VERIFY;
                end
            end
            VERIFY: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = count;
                count_nxt = count + 1'b1;
                if (count == LAST_ADDR) state_nxt = CHECK_LAST;
            end
            CHECK_LAST: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= '0;
            locked   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            done  <= run_ok;
            if (start_accept) begin
                error    <= 1'b0;
                err_addr <= '0;
            end else if (mismatch && !error) begin
                error    <= 1'b1;
                err_addr <= cmp_addr;
            end
            if (run_ok) locked <= 1'b1;
        end
    end

    // Shadow contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clock) begin
        if (handshake) shadow[count] <= in_data;
    end

endmodule

// File: tb/tb_prom_writer.sv
// Bench for prom_writer: registered-read memory model, write-strobe scoreboard,
// and one task per scenario.
module tb_prom_writer;

    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int W     = AW + DW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rd_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_addr;
    logic          locked;

    prom_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_addr    (err_addr),
        .locked      (locked)
    );

    // clock / reset block
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // registered-read memory model with optional corruption of addresses 5 and 9
    logic [DW-1:0] mem [DEPTH];
    bit            corrupt_en = 1'b0;
    always @(posedge clock) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) begin
            if (corrupt_en && mem_addr == 4'd5)      mem_rd_data <= '0;
            else if (corrupt_en && mem_addr == 4'd9) mem_rd_data <= ~mem[mem_addr];
            else                                     mem_rd_data <= mem[mem_addr];
        end
    end

    // scoreboard and counters
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] stream [DEPTH];
    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_cnt   = 0;
    int first_wr_cyc = -1;

    always @(negedge clock) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        if (!reset) begin
            if (in_ready && first_wr_cyc < 0) first_wr_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) begin
                n_checks++;
                if (mem_wr_en && mem_rd_en)
                    $display("FAIL strobe_overlap: got wr_en=1 rd_en=1 expected never both");
                else
                    n_pass++;
            end
            if (mem_wr_en) begin
                wr_cnt++;
                n_checks++;
                got_v = {mem_addr, mem_wr_data};
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: got addr=%0d data=%0d expected no strobe",
                             mem_addr, mem_wr_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v)
                        $display("FAIL write_strobe: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                 got_v[W-1:DW], got_v[DW-1:0], exp_v[W-1:DW], exp_v[DW-1:0]);
                    else
                        n_pass++;
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_stream(input int n_words, input bit bubbles, input bit verify_start);
        bit accepted;
        for (int i = 0; i < n_words; i++) begin
            exp_q.push_back({AW'(i), stream[i]});
            in_valid = 1'b1;
            in_data  = stream[i];
            accepted = 1'b0;
            for (int t = 0; t < 50 && !accepted; t++) begin
                @(negedge clock);
                if (in_ready) accepted = 1'b1;
                step();
            end
            in_valid = 1'b0;
            if (!accepted) begin
                n_checks++;
                $display("FAIL handshake_timeout: got no in_ready for word %0d expected accept", i);
                return;
            end
            if (bubbles && i < DEPTH - 1) step();
        end
        if (n_words == DEPTH) begin
            @(negedge clock);
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL ready_drop: got in_ready=%b expected 0", in_ready);
            else n_pass++;
            if (verify_start) begin
                step();
                pulse_start();
            end
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int t = 0; t < 100 && !idle; t++) begin
            @(negedge clock);
            if (!busy) idle = 1'b1;
        end
        if (!idle) begin
            n_checks++;
            $display("FAIL idle_timeout: got busy=1 expected return to idle");
        end
        step();
    endtask

    task automatic run_full(input bit bubbles, input bit verify_start, input int exp_len);
        done_cnt     = 0;
        wr_cnt       = 0;
        first_wr_cyc = -1;
        pulse_start();
        send_stream(DEPTH, bubbles, verify_start);
        wait_idle();
        n_checks += 6;
        if (wr_cnt !== DEPTH) $display("FAIL write_count: got %0d expected %0d", wr_cnt, DEPTH);
        else n_pass++;
        if (exp_q.size() !== 0) $display("FAIL sb_drain: got %0d left expected 0", exp_q.size());
        else n_pass++;
        if (done_cnt !== 1) $display("FAIL done_count: got %0d expected 1", done_cnt);
        else n_pass++;
        if (done_cyc - first_wr_cyc !== exp_len)
            $display("FAIL run_length: got %0d expected %0d", done_cyc - first_wr_cyc, exp_len);
        else n_pass++;
        if (locked !== 1'b1) $display("FAIL locked_set: got %b expected 1", locked);
        else n_pass++;
        if (error !== 1'b0) $display("FAIL error_clear: got %b expected 0", error);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", done);
        else n_pass++;
    endtask

    // scenarios
    task automatic test_reset();
        logic [18:0] outs;
        apply_reset();
        @(negedge clock);
        outs = {in_ready, mem_wr_en, mem_addr, mem_wr_data, mem_rd_en, busy, done, error,
                err_addr, locked};
        n_checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
        else n_pass++;
        step();
    endtask

    task automatic test_basic();
        run_full(1'b0, 1'b0, 33);
    endtask

    task automatic test_locked_ignore();
        wr_cnt   = 0;
        in_valid = 1'b1;
        in_data  = 4'd5;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0)
                $display("FAIL locked_ignore: got in_ready=%b busy=%b expected 0 0", in_ready, busy);
            else n_pass++;
        end
        step();
        in_valid = 1'b0;
        n_checks += 2;
        if (wr_cnt !== 0) $display("FAIL locked_writes: got %0d expected 0", wr_cnt);
        else n_pass++;
        if (locked !== 1'b1) $display("FAIL locked_hold: got %b expected 1", locked);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        logic [18:0] outs;
        pulse_start();
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL locked_before_reset: got in_ready=%b expected 0", in_ready);
        else n_pass++;
        apply_reset();
        pulse_start();
        send_stream(7, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = stream[7];
        #2;
        reset = 1'b1;
        #1;
        outs = {in_ready, mem_wr_en, mem_addr, mem_wr_data, mem_rd_en, busy, done, error,
                err_addr, locked};
        n_checks++;
        if (outs !== '0) $display("FAIL async_reset_outputs: got %h expected 0", outs);
        else n_pass++;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
        step();
        run_full(1'b0, 1'b0, 33);
    endtask

    task automatic test_bubbles();
        apply_reset();
        run_full(1'b1, 1'b0, 48);
    endtask

    task automatic test_corrupt_retry();
        apply_reset();
        corrupt_en   = 1'b1;
        done_cnt     = 0;
        pulse_start();
        send_stream(DEPTH, 1'b0, 1'b0);
        wait_idle();
        n_checks += 4;
        if (error !== 1'b1) $display("FAIL corrupt_error: got %b expected 1", error);
        else n_pass++;
        if (err_addr !== 4'd5) $display("FAIL corrupt_err_addr: got %0d expected 5", err_addr);
        else n_pass++;
        if (done_cnt !== 0) $display("FAIL corrupt_done: got %0d expected 0", done_cnt);
        else n_pass++;
        if (locked !== 1'b0) $display("FAIL corrupt_locked: got %b expected 0", locked);
        else n_pass++;
        corrupt_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (error !== 1'b0) $display("FAIL retry_error_cleared: got %b expected 0", error);
        else n_pass++;
        apply_reset();
        run_full(1'b0, 1'b0, 33);
    endtask

    task automatic test_start_in_verify();
        apply_reset();
        run_full(1'b0, 1'b1, 33);
    endtask

    initial begin
        stream = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0,
                   4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
        test_reset();
        test_basic();
        test_locked_ignore();
        test_reset_mid_write();
        test_bubbles();
        test_corrupt_retry();
        test_start_in_verify();
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
